// File: rtl/ps2_key_tracker.sv
// Turns PS/2 set-2 scan-code bytes into held-key state, resolved left/right direction and key events.
// Optional build macro: PS2_KEY_TYPEMATIC_FILTER_EN suppresses events for repeat makes of held keys.
module ps2_key_tracker #(
   parameter int TIMEOUT_CYCLES = 2500000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic [7:0] received_data,
   input  logic       received_data_en,
   output logic [4:0] held,
   output logic       move_right,
   output logic       move_left,
   output logic       key_event,
   output logic [2:0] key_event_id,
   output logic       key_event_break,
   output logic       seq_error
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] tmo_cnt;
   logic          timeout;
   logic          complete, is_brk, is_ext, set_err;
   logic          key_hit;
   logic [2:0]    key_id;
   logic [4:0]    held_nx;
   logic          last_h, last_h_nx;   // 0 = right made last, 1 = left made last
   logic          event_nx, right_nx, left_nx;

   // A strobe in the expiry cycle wins over the timeout.
   assign timeout = (state != IDLE) && !received_data_en &&
                    (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nx = state;
      complete = 1'b0;
      is_brk   = 1'b0;
      is_ext   = 1'b0;
      set_err  = 1'b0;
      if (received_data_en) begin
         case (state)
            IDLE: begin
               if (received_data == 8'hE0)      state_nx = EXT;
               else if (received_data == 8'hF0) state_nx = BRK;
               else                             complete = 1'b1;
            end
            EXT: begin
               state_nx = IDLE;
               if (received_data == 8'hF0)      state_nx = EXT_BRK;
               else if (received_data == 8'hE0) set_err  = 1'b1;
               else begin
                  complete = 1'b1;
                  is_ext   = 1'b1;
               end
            end
            BRK, EXT_BRK: begin
               state_nx = IDLE;
               if (received_data == 8'hF0 || received_data == 8'hE0) set_err = 1'b1;
               else begin
                  complete = 1'b1;
                  is_brk   = 1'b1;
                  is_ext   = (state == EXT_BRK);
               end
            end
            default: state_nx = IDLE;
         endcase
      end else if (timeout) begin
         state_nx = IDLE;
         set_err  = 1'b1;
      end
   end

   always_comb begin
      key_hit = 1'b0;
      key_id  = 3'd0;
      if (complete) begin
         case (received_data)
            8'h74:   begin key_hit = 1'b1;    key_id = 3'd0; end
            8'h6B:   begin key_hit = 1'b1;    key_id = 3'd1; end
            8'h75:   begin key_hit = 1'b1;    key_id = 3'd2; end
            8'h72:   begin key_hit = 1'b1;    key_id = 3'd3; end
            8'h29:   begin key_hit = !is_ext; key_id = 3'd4; end
            default: key_hit = 1'b0;
         endcase
      end
   end

   always_comb begin
      held_nx   = held;
      last_h_nx = last_h;
      event_nx  = 1'b0;
      if (key_hit) begin
         if (is_brk) begin
            held_nx[key_id] = 1'b0;
            event_nx        = 1'b1;
`ifdef PS2_KEY_TYPEMATIC_FILTER_EN
         end else if (!held[key_id]) begin
`else
         end else begin
`endif
            held_nx[key_id] = 1'b1;
            event_nx        = 1'b1;
            if (key_id == 3'd0)      last_h_nx = 1'b0;
            else if (key_id == 3'd1) last_h_nx = 1'b1;
         end
      end
   end

   always_comb begin
      right_nx = 1'b0;
      left_nx  = 1'b0;
      case ({held_nx[1], held_nx[0]})
         2'b11: begin
            right_nx = !last_h_nx;
            left_nx  = last_h_nx;
         end
         2'b01:   right_nx = 1'b1;
         2'b10:   left_nx  = 1'b1;
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         tmo_cnt <= '0;
      end else begin
         state <= state_nx;
         if (received_data_en || state == IDLE) tmo_cnt <= '0;
         else                                   tmo_cnt <= tmo_cnt + CW'(1);
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         held            <= '0;
         last_h          <= 1'b0;
         move_right      <= 1'b0;
         move_left       <= 1'b0;
         key_event       <= 1'b0;
         key_event_id    <= 3'd0;
         key_event_break <= 1'b0;
         seq_error       <= 1'b0;
      end else begin
         held       <= held_nx;
         last_h     <= last_h_nx;
         move_right <= right_nx;
         move_left  <= left_nx;
         key_event  <= event_nx;
         if (event_nx) begin
            key_event_id    <= key_id;
            key_event_break <= is_brk;
         end
         if (set_err) seq_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: stimulus pushes expected events, a monitor pops them on key_event.
module tb_ps2_key_tracker;

   localparam int T = 20;

   logic       CLOCK_50 = 1'b0;
   logic       resetn;
   logic [7:0] received_data;
   logic       received_data_en;
   logic [4:0] held;
   logic       move_right, move_left, key_event, key_event_break, seq_error;
   logic [2:0] key_event_id;

   int checks   = 0;
   int failures = 0;
   logic [11:0] exp_q[$];

   ps2_key_tracker #(.TIMEOUT_CYCLES(T)) dut (
      .CLOCK_50        (CLOCK_50),
      .resetn          (resetn),
      .received_data   (received_data),
      .received_data_en(received_data_en),
      .held            (held),
      .move_right      (move_right),
      .move_left       (move_left),
      .key_event       (key_event),
      .key_event_id    (key_event_id),
      .key_event_break (key_event_break),
      .seq_error       (seq_error)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Event record: {id, break, held, move_right, move_left, seq_error}.
   task automatic push_ev(input logic [2:0] id, input logic brk, input logic [4:0] h,
                          input logic mr, input logic ml, input logic err);
      exp_q.push_back({id, brk, h, mr, ml, err});
   endtask

   task automatic send(input logic [7:0] b);
      @(negedge CLOCK_50);
      received_data    = b;
      received_data_en = 1'b1;
   endtask

   task automatic idle(input int n);
      @(negedge CLOCK_50);
      received_data_en = 1'b0;
      repeat (n - 1) @(negedge CLOCK_50);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_held"},  32'(held), 32'h0);
      check({tag, "_mr"},    32'(move_right), 32'h0);
      check({tag, "_ml"},    32'(move_left), 32'h0);
      check({tag, "_ev"},    32'(key_event), 32'h0);
      check({tag, "_id"},    32'(key_event_id), 32'h0);
      check({tag, "_brk"},   32'(key_event_break), 32'h0);
      check({tag, "_err"},   32'(seq_error), 32'h0);
   endtask

   initial begin : monitor
      logic [11:0] act;
      forever begin
         @(negedge CLOCK_50);
         if (key_event === 1'b1) begin
            act = {key_event_id, key_event_break, held, move_right, move_left, seq_error};
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_event: got=%0h expected=none", act);
            end else begin
               check("event", 32'(act), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin : watchdog
      repeat (20000) @(posedge CLOCK_50);
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      resetn           = 1'b0;
      received_data    = 8'h00;
      received_data_en = 1'b0;
      repeat (3) @(negedge CLOCK_50);
      check_all_zero("reset");
      resetn = 1'b1;
      idle(2);

      // Plain make then break of up.
      push_ev(3'd2, 1'b0, 5'b00100, 1'b0, 1'b0, 1'b0);
      send(8'h75); idle(1);
      check("up_held", 32'(held), 32'h04);
      idle(1);
      check("up_pulse_one_cycle", 32'(key_event), 32'h0);
      push_ev(3'd2, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0);
      send(8'hF0); send(8'h75); idle(2);
      check("ev_id_holds", 32'(key_event_id), 32'h2);
      check("ev_brk_holds", 32'(key_event_break), 32'h1);
      check("ev_low_after", 32'(key_event), 32'h0);

      // Extended right then left: last pressed wins; releasing left returns to right.
      push_ev(3'd0, 1'b0, 5'b00001, 1'b1, 1'b0, 1'b0);
      push_ev(3'd1, 1'b0, 5'b00011, 1'b0, 1'b1, 1'b0);
      send(8'hE0); send(8'h74); send(8'hE0); send(8'h6B); idle(1);
      check("both_left_wins", 32'({move_right, move_left}), 32'h1);
      push_ev(3'd1, 1'b1, 5'b00001, 1'b1, 1'b0, 1'b0);
      send(8'hE0); send(8'hF0); send(8'h6B); idle(1);
      check("left_released", 32'({move_right, move_left}), 32'h2);

      // Ignored codes: E0 29 and an unmapped make.
      send(8'hE0); send(8'h29); send(8'h12); idle(2);
      check("ignored_held", 32'(held), 32'h01);

      // Typematic repeats of right.
      push_ev(3'd0, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0);
      send(8'hF0); send(8'h74); idle(1);
      push_ev(3'd0, 1'b0, 5'b00001, 1'b1, 1'b0, 1'b0);
`ifndef PS2_KEY_TYPEMATIC_FILTER_EN
      push_ev(3'd0, 1'b0, 5'b00001, 1'b1, 1'b0, 1'b0);
      push_ev(3'd0, 1'b0, 5'b00001, 1'b1, 1'b0, 1'b0);
`endif
      send(8'h74); send(8'h74); send(8'h74); idle(2);

      // Repeat make of right while left wins.
      push_ev(3'd1, 1'b0, 5'b00011, 1'b0, 1'b1, 1'b0);
`ifndef PS2_KEY_TYPEMATIC_FILTER_EN
      push_ev(3'd0, 1'b0, 5'b00011, 1'b1, 1'b0, 1'b0);
`endif
      send(8'h6B); send(8'h74); idle(1);
`ifdef PS2_KEY_TYPEMATIC_FILTER_EN
      check("repeat_dir", 32'({move_right, move_left}), 32'h1);
      push_ev(3'd0, 1'b1, 5'b00010, 1'b0, 1'b1, 1'b0);
`else
      check("repeat_dir", 32'({move_right, move_left}), 32'h2);
      push_ev(3'd0, 1'b1, 5'b00010, 1'b0, 1'b1, 1'b0);
`endif
      send(8'hF0); send(8'h74);
      push_ev(3'd1, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0);
      send(8'hF0); send(8'h6B); idle(1);
      check("none_dir", 32'({move_right, move_left}), 32'h0);

      // Strobe in the expiry cycle beats the timeout.
      push_ev(3'd0, 1'b0, 5'b00001, 1'b1, 1'b0, 1'b0);
      send(8'h74); idle(1);
      push_ev(3'd0, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0);
      send(8'hE0); idle(T - 1); send(8'hF0); send(8'h74); idle(1);
      check("edge_no_err", 32'(seq_error), 32'h0);

      // F0 F0 sets the error; trailing 29 is a make of space.
      push_ev(3'd4, 1'b0, 5'b10000, 1'b0, 1'b0, 1'b1);
      send(8'hF0); send(8'hF0); send(8'h29); idle(1);
      check("f0f0_err", 32'(seq_error), 32'h1);

      // Asynchronous reset in the middle of E0 F0 74.
      push_ev(3'd0, 1'b0, 5'b10001, 1'b1, 1'b0, 1'b1);
      send(8'h74); send(8'hE0); idle(1);
      #2 resetn = 1'b0;
      #1 check_all_zero("midreset");
      idle(2);
      resetn = 1'b1;
      push_ev(3'd0, 1'b0, 5'b00001, 1'b1, 1'b0, 1'b0);
      send(8'h74); idle(1);
      check("after_reset_held", 32'(held), 32'h01);

      // Timeout after E0.
      push_ev(3'd0, 1'b1, 5'b00000, 1'b0, 1'b0, 1'b0);
      send(8'hF0); send(8'h74); idle(1);
      send(8'hE0); idle(T);
      check("tmo_not_yet", 32'(seq_error), 32'h0);
      @(negedge CLOCK_50);
      check("tmo_err", 32'(seq_error), 32'h1);
      check("tmo_held", 32'(held), 32'h0);
      push_ev(3'd0, 1'b0, 5'b00001, 1'b1, 1'b0, 1'b1);
      send(8'h74); idle(3);
      check("tmo_then_make", 32'(held), 32'h01);

      check("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Sequences the byte stream from the PS/2 controller (`received_data` / `received_data_en`) into held-key state for game control. Decodes scan-code set 2 make, break (`F0`) and extended (`E0`) sequences, keeping a held bit for five keys. Resolves left/right conflicts with last-pressed-wins and emits a one-cycle event pulse per key transition. Sits between `PS2_Controller` and the player-movement logic; it replaces ad-hoc `last_data_received` decoding.

## Interface
- `TIMEOUT_CYCLES`, default 2500000: idle cycles (50 ms at 50 MHz) after a prefix byte before the sequence is abandoned.
- `CLOCK_50`  in  1  system clock; all state on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `received_data`  in  8  byte from `PS2_Controller`; valid only when `received_data_en`=1.
- `received_data_en`  in  1  one-cycle strobe per received byte.
- `held`  out  5  held keys {space, down, up, left, right} = bits [4:0]; reset 0.
- `move_right`  out  1  resolved horizontal direction; reset 0.
- `move_left`  out  1  resolved horizontal direction; reset 0; never both 1 with `move_right`.
- `key_event`  out  1  one-cycle pulse on accepted make/break; reset 0.
- `key_event_id`  out  3  key index 0..4 of the event; reset 0.
- `key_event_break`  out  1  1 = release, 0 = press; reset 0.
- `seq_error`  out  1  sticky; set on timeout or `F0 F0`/`E0 E0`; cleared only by reset; reset 0.

## Operation
- Key map, codes accepted with or without `E0` prefix: `74` right(0), `6B` left(1), `75` up(2), `72` down(3). `29` is space(4) only without `E0`; `E0 29` is ignored. All other codes complete the sequence with no effect.
- FSM states: IDLE, EXT (after `E0`), BRK (after `F0`), EXT_BRK (after `E0 F0`).
- Transitions on a strobe:
  - IDLE: `E0`→EXT; `F0`→BRK; other byte → make, stay IDLE.
  - EXT: `F0`→EXT_BRK; `E0`→IDLE and set `seq_error`; other byte → extended make, →IDLE.
  - BRK: `F0` or `E0`→IDLE and set `seq_error`; other byte → break, →IDLE.
  - EXT_BRK: `F0` or `E0`→IDLE and set `seq_error`; other byte → extended break, →IDLE.
- Make of mapped key: set `held[id]`. Break: clear `held[id]`. Break of a key not held still clears it (no-op) and still pulses `key_event`.
- Direction resolution: a register `last_h` records whichever of right/left was most recently made.
  - Both held: the `last_h` direction wins.
  - One held: that direction wins.
  - Neither held: both outputs 0.
  - Break of the winning key while the other is still held: direction switches to the other key.
- Timeout: a counter runs while the FSM is not IDLE and clears on every strobe. At `TIMEOUT_CYCLES` the FSM goes to IDLE and sets `seq_error`; `held` is not modified.
- `seq_error` has no other effect on operation.

## Timing
- All outputs are registered.
- `held`, `move_*`, `key_event*` update on the clock edge following the cycle in which the completing byte's strobe is high: latency 1 cycle.
- `key_event` is high for exactly one cycle. `key_event_id`/`key_event_break` hold their values until the next event.
- Strobes arrive at most one per cycle. Back-to-back strobes on consecutive cycles must each be processed; the FSM has no stall.
- Timeout fires on the cycle the counter reaches `TIMEOUT_CYCLES`-1. A strobe arriving in that same cycle has priority: it is processed normally and there is no error.
- Reset asserted mid-sequence: all state and outputs return to reset values asynchronously. A partial sequence is discarded.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`.

## Configuration
- `PS2_KEY_TYPEMATIC_FILTER_EN`
  - Defined: a make of a key whose `held` bit is already 1 (typematic repeat) produces no `key_event` and causes no `last_h` change.
  - Undefined: every make pulses `key_event`. A repeat make of right/left re-captures `last_h`.

## Test plan
- Reset, then `75` → `held`=00100, `key_event`=1 for one cycle, id=2, break=0. Then `F0 75` → `held`=0, event id=2, break=1.
- `E0 74`, then `E0 6B` → `move_left`=1, `move_right`=0. Then `E0 F0 6B` → `move_right`=1.
- `E0`, then no strobe for `TIMEOUT_CYCLES` → FSM returns to IDLE, `seq_error`=1. A following `74` then sets `held[0]`.
- `F0 F0 29` → `seq_error`=1, `held`=0. The trailing `29` is treated as a make: `held[4]`=1.
- `E0 29` and `12` → no `key_event`, `held` unchanged. `74 74 74` with the macro defined gives 1 event; with the macro undefined it gives 3.
- Assert `resetn`=0 between `E0` and `F0` of `E0 F0 74` while `held[0]`=1 → all outputs 0. After release, `74` alone sets `held[0]` again.
